// File: rtl/mips_pkg.sv
// Shared MIPS datapath constants: MDU op encodings, MDU FSM states and result constants.
package mips_pkg;

  localparam logic [1:0] MDU_MULT  = 2'b00;
  localparam logic [1:0] MDU_MULTU = 2'b01;
  localparam logic [1:0] MDU_DIV   = 2'b10;
  localparam logic [1:0] MDU_DIVU  = 2'b11;

  localparam logic [1:0] MDU_ST_IDLE   = 2'd0;
  localparam logic [1:0] MDU_ST_CALC   = 2'd1;
  localparam logic [1:0] MDU_ST_FINISH = 2'd2;

  // Quotient on divide-by-zero; sliced down to the unit's WIDTH (<= 64).
  localparam logic [63:0] MDU_DIV0_LO = '1;

  typedef struct packed {
    logic is_div;
    logic neg_prod;
    logic neg_q;
    logic neg_r;
    logic div0;
  } mdu_flags_t;

endpackage

// File: rtl/mdu_if.sv
// Control-unit <-> MDU handshake and HI/LO access bundle.
interface mdu_if #(parameter int WIDTH = 32);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             hi_we;
  logic             lo_we;
  logic [WIDTH-1:0] wdata;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (output start, op, a, b, hi_we, lo_we, wdata,
                  input  busy, done, hi, lo);
  modport slave  (input  start, op, a, b, hi_we, lo_we, wdata,
                  output busy, done, hi, lo);
endinterface

// File: rtl/mdu_div_step.sv
// One restoring-divide iteration: shift in the next dividend bit, trial-subtract, keep or restore.
module mdu_div_step #(parameter int WIDTH = 32) (
  input  logic [WIDTH-1:0] rem,
  input  logic [WIDTH-1:0] quo,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_nxt,
  output logic [WIDTH-1:0] quo_nxt
);
  logic [WIDTH:0] rem_sh;
  logic [WIDTH:0] diff;

  assign rem_sh = {rem, quo[WIDTH-1]};
  assign diff   = rem_sh - {1'b0, divisor};

  // No borrow out of the trial subtract means this quotient bit is 1.
  assign rem_nxt = diff[WIDTH] ? rem_sh[WIDTH-1:0] : diff[WIDTH-1:0];
  assign quo_nxt = {quo[WIDTH-2:0], ~diff[WIDTH]};
endmodule

// File: rtl/mdu.sv
// Iterative MULT/MULTU/DIV/DIVU unit owning HI/LO. Define MDU_FAST_MULT_EN for a
// single-cycle combinational multiply; divide stays iterative either way.
module mdu import mips_pkg::*; #(parameter int WIDTH = 32) (
  input  logic   clk,
  input  logic   reset,
  mdu_if.slave   bus
);
  localparam int CW = $clog2(WIDTH);

  logic [1:0]       state;
  logic [CW-1:0]    cnt;
  mdu_flags_t       flg;
  logic [WIDTH-1:0] mag_a, mag_b, a_raw;
  logic [WIDTH-1:0] acc_hi, acc_lo;
  logic [WIDTH-1:0] hi_q, lo_q;
  logic             done_q;

  logic             sign_a, sign_b;
  logic [WIDTH-1:0] abs_a, abs_b;
  logic [WIDTH:0]   msum;
  logic [WIDTH-1:0] rem_nxt, quo_nxt;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0] q_fix, r_fix;

  // op[0]==0 selects the signed variants (MULT, DIV).
  assign sign_a = ~bus.op[0] & bus.a[WIDTH-1];
  assign sign_b = ~bus.op[0] & bus.b[WIDTH-1];
  assign abs_a  = sign_a ? -bus.a : bus.a;
  assign abs_b  = sign_b ? -bus.b : bus.b;

  // Shift-add: acc_lo starts as the multiplier and is consumed LSB first.
  assign msum = {1'b0, acc_hi} + {1'b0, (acc_lo[0] ? mag_a : {WIDTH{1'b0}})};

  mdu_div_step #(.WIDTH(WIDTH)) u_div_step (
    .rem     (acc_hi),
    .quo     (acc_lo),
    .divisor (mag_b),
    .rem_nxt (rem_nxt),
    .quo_nxt (quo_nxt)
  );

  assign prod_fix = flg.neg_prod ? -{acc_hi, acc_lo} : {acc_hi, acc_lo};
  assign q_fix    = flg.neg_q ? -acc_lo : acc_lo;
  assign r_fix    = flg.neg_r ? -acc_hi : acc_hi;

`ifdef MDU_FAST_MULT_EN
  logic [2*WIDTH-1:0] fast_prod;
  assign fast_prod = {{WIDTH{1'b0}}, abs_a} * {{WIDTH{1'b0}}, abs_b};
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= MDU_ST_IDLE;
      cnt    <= '0;
      flg    <= '0;
      mag_a  <= '0;
      mag_b  <= '0;
      a_raw  <= '0;
      acc_hi <= '0;
      acc_lo <= '0;
      hi_q   <= '0;
      lo_q   <= '0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        MDU_ST_IDLE: begin
          if (bus.hi_we) hi_q <= bus.wdata;
          if (bus.lo_we) lo_q <= bus.wdata;
          if (bus.start) begin
            flg.is_div   <= bus.op[1];
            flg.neg_prod <= ~bus.op[1] & (sign_a ^ sign_b);
            flg.neg_q    <= bus.op[1] & (sign_a ^ sign_b);
            flg.neg_r    <= bus.op[1] & sign_a;
            flg.div0     <= bus.op[1] & (bus.b == '0);
            mag_a        <= abs_a;
            mag_b        <= abs_b;
            a_raw        <= bus.a;
            cnt          <= '0;
            acc_hi       <= '0;
            acc_lo       <= bus.op[1] ? abs_a : abs_b;
            state        <= MDU_ST_CALC;
`ifdef MDU_FAST_MULT_EN
            if (!bus.op[1]) begin
              {acc_hi, acc_lo} <= fast_prod;
              state            <= MDU_ST_FINISH;
            end
`endif
          end
        end
        MDU_ST_CALC: begin
          if (flg.is_div) {acc_hi, acc_lo} <= {rem_nxt, quo_nxt};
          else            {acc_hi, acc_lo} <= {msum, acc_lo[WIDTH-1:1]};
          cnt <= cnt + 1'b1;
          if (cnt == CW'(WIDTH-1)) state <= MDU_ST_FINISH;
        end
        MDU_ST_FINISH: begin
          if (!flg.is_div) begin
            {hi_q, lo_q} <= prod_fix;
          end else if (flg.div0) begin
            hi_q <= a_raw;
            lo_q <= MDU_DIV0_LO[WIDTH-1:0];
          end else begin
            hi_q <= r_fix;
            lo_q <= q_fix;
          end
          done_q <= 1'b1;
          state  <= MDU_ST_IDLE;
        end
        default: state <= MDU_ST_IDLE;
      endcase
    end
  end

  assign bus.busy = (state != MDU_ST_IDLE);
  assign bus.done = done_q;
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;
endmodule

// File: tb/tb_mdu.sv
// Directed vector bench for mdu: result table plus handshake/abort/write sequences.
module tb_mdu;
  import mips_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  mdu_if #(.WIDTH(32)) bus ();
  mdu #(.WIDTH(32)) dut (.clk(clk), .reset(reset), .bus(bus));

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a, b, ehi, elo;
  } vec_t;

  vec_t vecs[14];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%h want=%h", name, act, exp);
    end
  endtask

  function automatic int exp_lat(input logic [1:0] op);
`ifdef MDU_FAST_MULT_EN
    return op[1] ? 33 : 1;
`else
    return 33;
`endif
  endfunction

  // Issue one op (start sampled at E0), wait for done with a bound, report latency.
  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        output int lat, output int busy_bad);
    lat = -1;
    busy_bad = 0;
    bus.start = 1'b1; bus.op = op; bus.a = a; bus.b = b;
    @(posedge clk); #1;
    bus.start = 1'b0;
    if (bus.busy !== 1'b1) busy_bad++;
    for (int k = 1; k <= 45; k++) begin
      @(posedge clk); #1;
      if (bus.done === 1'b1) begin
        lat = k;
        if (bus.busy !== 1'b0) busy_bad++;
        break;
      end
      if (bus.busy !== 1'b1) busy_bad++;
    end
  endtask

  initial begin
    int lat, bb, ndone;

    vecs[0]  = '{MDU_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
    vecs[1]  = '{MDU_MULT,  32'hFFFFFFFD, 32'd7,        32'hFFFFFFFF, 32'hFFFFFFEB};
    vecs[2]  = '{MDU_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};
    vecs[3]  = '{MDU_DIV,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD};
    vecs[4]  = '{MDU_DIVU,  32'd100,      32'd7,        32'd2,        32'd14};
    vecs[5]  = '{MDU_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
    vecs[6]  = '{MDU_DIVU,  32'h00001234, 32'd0,        32'h00001234, 32'hFFFFFFFF};
    vecs[7]  = '{MDU_DIV,   32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD};
    vecs[8]  = '{MDU_DIV,   32'hFFFFFFFB, 32'd0,        32'hFFFFFFFB, 32'hFFFFFFFF};
    vecs[9]  = '{MDU_MULTU, 32'd6,        32'd7,        32'd0,        32'd42};
    vecs[10] = '{MDU_MULT,  32'd5,        32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFB};
    vecs[11] = '{MDU_DIVU,  32'hFFFFFFFF, 32'd1,        32'd0,        32'hFFFFFFFF};
    vecs[12] = '{MDU_DIV,   32'hFFFFFFF8, 32'hFFFFFFFD, 32'hFFFFFFFE, 32'd2};
    vecs[13] = '{MDU_MULTU, 32'h0001_0000, 32'h0001_0000, 32'd1,      32'd0};

    bus.start = 1'b0; bus.op = 2'b00; bus.a = '0; bus.b = '0;
    bus.hi_we = 1'b0; bus.lo_we = 1'b0; bus.wdata = '0;

    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    chk("rst_hi", bus.hi, 32'h0);
    chk("rst_lo", bus.lo, 32'h0);
    chk("rst_busy", {31'b0, bus.busy}, 32'h0);
    chk("rst_done", {31'b0, bus.done}, 32'h0);

    // MTHI / MTLO in IDLE
    bus.hi_we = 1'b1; bus.wdata = 32'hDEADBEEF;
    @(posedge clk); #1;
    bus.hi_we = 1'b0;
    chk("mthi", bus.hi, 32'hDEADBEEF);
    bus.lo_we = 1'b1; bus.wdata = 32'h11111111;
    @(posedge clk); #1;
    bus.lo_we = 1'b0;
    chk("mtlo", bus.lo, 32'h11111111);

    for (int i = 0; i < 14; i++) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, lat, bb);
      chk($sformatf("v%0d_lat", i), 32'(lat), 32'(exp_lat(vecs[i].op)));
      chk($sformatf("v%0d_busy", i), 32'(bb), 32'd0);
      chk($sformatf("v%0d_hi", i), bus.hi, vecs[i].ehi);
      chk($sformatf("v%0d_lo", i), bus.lo, vecs[i].elo);
      @(posedge clk); #1;
      chk($sformatf("v%0d_done_pulse", i), {31'b0, bus.done}, 32'h0);
    end

    // Second start at E5 must be ignored
    ndone = 0;
    bus.start = 1'b1; bus.op = MDU_DIVU; bus.a = 32'd100; bus.b = 32'd7;
    @(posedge clk); #1;  // E0
    bus.start = 1'b0;
    for (int k = 1; k <= 45; k++) begin
      if (k == 5) begin bus.start = 1'b1; bus.op = MDU_MULTU; bus.a = 32'd3; bus.b = 32'd3; end
      @(posedge clk); #1;
      if (k == 5) bus.start = 1'b0;
      if (bus.done === 1'b1) begin
        ndone++;
        if (ndone == 1) chk("dup_lat", 32'(k), 32'd33);
      end
    end
    chk("dup_ndone", 32'(ndone), 32'd1);
    chk("dup_hi", bus.hi, 32'd2);
    chk("dup_lo", bus.lo, 32'd14);

    // MTLO/MTHI while busy are dropped
    bus.start = 1'b1; bus.op = MDU_DIVU; bus.a = 32'd100; bus.b = 32'd7;
    @(posedge clk); #1;  // E0
    bus.start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;  // E2
    bus.lo_we = 1'b1; bus.hi_we = 1'b1; bus.wdata = 32'hCAFEF00D;
    @(posedge clk); #1;  // E3
    bus.lo_we = 1'b0; bus.hi_we = 1'b0;
    chk("busy_we_lo", bus.lo, 32'd14);
    chk("busy_we_hi", bus.hi, 32'd2);
    lat = -1;
    for (int k = 4; k <= 45; k++) begin
      @(posedge clk); #1;
      if (bus.done === 1'b1) begin lat = k; break; end
    end
    chk("busy_we_lat", 32'(lat), 32'd33);

    // MTHI in the same cycle as start: written, then overwritten by the result
    bus.hi_we = 1'b1; bus.wdata = 32'h0000ABCD;
    run_op(MDU_MULTU, 32'd6, 32'd7, lat, bb);
    bus.hi_we = 1'b0;
    chk("st_we_hi", bus.hi, 32'd0);
    chk("st_we_lo", bus.lo, 32'd42);

    // Reset at E10 aborts with no result and no done
    bus.hi_we = 1'b1; bus.wdata = 32'h5A5A5A5A;
    @(posedge clk); #1;
    bus.hi_we = 1'b0;
    bus.start = 1'b1; bus.op = MDU_DIV; bus.a = 32'd1000; bus.b = 32'd3;
    @(posedge clk); #1;  // E0
    bus.start = 1'b0;
    repeat (9) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1;  // E10
    reset = 1'b0;
    chk("abort_busy", {31'b0, bus.busy}, 32'h0);
    chk("abort_hi", bus.hi, 32'h0);
    chk("abort_lo", bus.lo, 32'h0);
    ndone = 0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk); #1;
      if (bus.done === 1'b1 || bus.busy === 1'b1) ndone++;
    end
    chk("abort_quiet", 32'(ndone), 32'd0);
    chk("abort_lo_after", bus.lo, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got=running want=finished");
    $fatal(1, "timeout");
  end
endmodule
